bsg_decode_one_hot_pipe: RTL and testbench
==========================================

BSG_DECODE_ONE_HOT_PIPE -- requirements
Module: bsg_decode_one_hot_pipe

Interface
REQ-001 The block SHALL have parameter width_p, default 32, meaning the number of one-hot output bits (2..64).
REQ-002 The block SHALL have parameter lo_to_hi_p, default 0, meaning the bit order: 0 maps address k to bit k, 1 maps address k to bit width_p-1-k.
REQ-003 The block SHALL have parameter addr_width_p, default clog2(width_p), meaning the width of the address input.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL provide port clk_i, input, 1 bit, the sole clock; all state updates occur on its rising edge.
REQ-006 The block SHALL provide port reset_i, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL provide port addr_i, input, addr_width_p bits, the binary address to decode.
REQ-008 The block SHALL provide port v_i, input, 1 bit, meaning addr_i is valid.
REQ-009 The block SHALL provide port ready_o, output, 1 bit, meaning the block can accept an address this cycle.
REQ-010 The block SHALL provide port o, output, width_p bits, the decoded one-hot word at the queue head.
REQ-011 The block SHALL provide port v_o, output, 1 bit, meaning o is valid.
REQ-012 The block SHALL provide port yumi_i, input, 1 bit, meaning the consumer takes o this cycle.

Function
REQ-013 The block SHALL accept an address when v_i and ready_o are both 1 at a rising edge.
REQ-014 The block SHALL decode each accepted in-range address (addr_i < width_p) into a word with exactly one bit set, positioned per lo_to_hi_p.
REQ-015 The block SHALL decode an out-of-range address (addr_i >= width_p) into an all-zero word, still enqueued with v_o asserted.
REQ-016 The block SHALL store decoded words in a 2-entry FIFO and deliver them in acceptance order.
REQ-017 The block SHALL drive ready_o = not full, and ready_o SHALL NOT depend combinationally on yumi_i or v_i.
REQ-018 The block SHALL drive v_o = not empty, and o SHALL equal the head entry when v_o=1 and all-zero when v_o=0.
REQ-019 The block SHALL have a latency of 1 cycle: an address accepted at edge N is visible on o/v_o after edge N.
REQ-020 The block SHALL dequeue the head when yumi_i=1; asserting yumi_i while v_o=0 is illegal and SHALL fire a simulation assertion.
REQ-021 The block SHALL perform a simultaneous enqueue and dequeue with 1 entry held, keeping occupancy at 1 and sustaining one word per cycle.
REQ-022 The block SHALL perform a simultaneous enqueue and dequeue from empty as an enqueue only, since v_o=0 forbids yumi_i.
REQ-023 The block SHALL ignore v_i while full (ready_o=0); the producer SHALL hold addr_i until accepted.
REQ-024 The block SHALL wrap its read and write pointers modulo 2 without occupancy error.
REQ-025 The block SHALL keep o stable while v_o=1 and yumi_i=0.

Reset
REQ-026 The block SHALL clear state on any edge where reset_i=1: FIFO empty, v_o=0, o=0, ready_o=1 from the following cycle.
REQ-027 The block SHALL ignore v_i and yumi_i while reset_i=1, and SHALL discard any queued words when reset is asserted mid-operation.

Configuration
REQ-028 The block SHALL use macro BSG_DECODE_ONE_HOT_PIPE_ERR_EN: when defined, an output port err_o (1 bit) exists and goes high the cycle after an out-of-range address is accepted.
REQ-029 When BSG_DECODE_ONE_HOT_PIPE_ERR_EN is defined, err_o SHALL remain high (sticky) until reset_i is asserted, with reset value 0.
REQ-030 When BSG_DECODE_ONE_HOT_PIPE_ERR_EN is undefined, the block SHALL have no err_o port and SHALL silently handle out-of-range addresses per REQ-015.

Verification
REQ-031 The bench SHALL cover: width_p=32, lo_to_hi_p=0, addr 5 accepted, yumi_i=1 next cycle -> o=0x00000020, v_o=1 for exactly one cycle.
REQ-032 The bench SHALL cover: lo_to_hi_p=1, addr 0 -> o=0x80000000; addr 31 -> o=0x00000001.
REQ-033 The bench SHALL cover: addrs 3 then 7 with yumi_i=0 -> ready_o=0 after the second accept; third addr 9 held until the first yumi; outputs 0x8, 0x80, 0x200 in order.
REQ-034 The bench SHALL cover: continuous v_i and yumi_i over addresses 0..31 -> 32 words in 32 consecutive cycles after 1-cycle latency, each one-hot.
REQ-035 The bench SHALL cover: width_p=24, macro defined, addr 30 -> o=0, v_o=1, err_o=1 the next cycle and held until reset; macro undefined -> o=0, no error port.
REQ-036 The bench SHALL cover: reset_i pulsed with 2 entries queued -> next cycle v_o=0, o=0, ready_o=1, and no stale word ever emitted.

Source files
------------

// File: rtl/bsg_decode_one_hot_pipe.sv
// Binary-to-one-hot decoder feeding a 2-entry output FIFO.
// Define BSG_DECODE_ONE_HOT_PIPE_ERR_EN to add a sticky out-of-range flag err_o.
module bsg_decode_one_hot_pipe #(
    parameter int width_p      = 32,
    parameter int lo_to_hi_p   = 0,
    parameter int addr_width_p = $clog2(width_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      o,
    output logic                    v_o,
    input  logic                    yumi_i
`ifdef BSG_DECODE_ONE_HOT_PIPE_ERR_EN
    ,
    output logic                    err_o
`endif
);

    logic [width_p-1:0] dec;
    logic [width_p-1:0] mem_r [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    // Out-of-range addresses match no bit and decode to zero.
    always_comb begin
        dec = '0;
        for (int i = 0; i < width_p; i++) begin
            if (int'(addr_i) == i) begin
                if (lo_to_hi_p != 0)
                    dec[width_p-1-i] = 1'b1;
                else
                    dec[i] = 1'b1;
            end
        end
    end

    assign ready_o = ~count_r[1];
    assign v_o     = |count_r;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign o       = v_o ? mem_r[rptr_r] : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq)
                wptr_r <= ~wptr_r;
            if (deq)
                rptr_r <= ~rptr_r;
            count_r <= count_r + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && enq)
            mem_r[wptr_r] <= dec;
    end

`ifdef BSG_DECODE_ONE_HOT_PIPE_ERR_EN
    logic err_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            err_r <= 1'b0;
        else if (enq && ~|dec)
            err_r <= 1'b1;
    end

    assign err_o = err_r;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(yumi_i && !v_o))
            else $error("yumi_i asserted while v_o is low");
    end
`endif

endmodule

// File: tb/tb_bsg_decode_one_hot_pipe.sv
// Randomized and directed bench for bsg_decode_one_hot_pipe.
// Three instances share stimulus: w32 lo, w32 hi-first, w24 lo.
module tb_bsg_decode_one_hot_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        v_i;
    logic        yumi_i;
    logic [4:0]  addr_i;
    logic        ready0, ready1, ready2;
    logic        v0, v1, v2;
    logic [31:0] o0, o1;
    logic [23:0] o2;
`ifdef BSG_DECODE_ONE_HOT_PIPE_ERR_EN
    logic        err0, err1, err2;
`endif

    bsg_decode_one_hot_pipe #(.width_p(32), .lo_to_hi_p(0)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .v_i(v_i),
        .ready_o(ready0), .o(o0), .v_o(v0), .yumi_i(yumi_i)
`ifdef BSG_DECODE_ONE_HOT_PIPE_ERR_EN
        , .err_o(err0)
`endif
    );

    bsg_decode_one_hot_pipe #(.width_p(32), .lo_to_hi_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .v_i(v_i),
        .ready_o(ready1), .o(o1), .v_o(v1), .yumi_i(yumi_i)
`ifdef BSG_DECODE_ONE_HOT_PIPE_ERR_EN
        , .err_o(err1)
`endif
    );

    bsg_decode_one_hot_pipe #(.width_p(24), .lo_to_hi_p(0)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .v_i(v_i),
        .ready_o(ready2), .o(o2), .v_o(v2), .yumi_i(yumi_i)
`ifdef BSG_DECODE_ONE_HOT_PIPE_ERR_EN
        , .err_o(err2)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int q[$];
    bit err_m  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_word(int w, bit rev, int a);
        if (a >= w)
            return 64'd0;
        return 64'd1 << (rev ? (w - 1 - a) : a);
    endfunction

    task automatic check_all();
        bit nonempty;
        nonempty = (q.size() != 0);
        check("v0", 64'(v0), 64'(nonempty));
        check("v1", 64'(v1), 64'(nonempty));
        check("v2", 64'(v2), 64'(nonempty));
        check("ready0", 64'(ready0), 64'(q.size() < 2));
        check("ready1", 64'(ready1), 64'(q.size() < 2));
        check("ready2", 64'(ready2), 64'(q.size() < 2));
        check("o0", 64'(o0), nonempty ? ref_word(32, 0, q[0]) : 64'd0);
        check("o1", 64'(o1), nonempty ? ref_word(32, 1, q[0]) : 64'd0);
        check("o2", 64'(o2), nonempty ? ref_word(24, 0, q[0]) : 64'd0);
`ifdef BSG_DECODE_ONE_HOT_PIPE_ERR_EN
        check("err0", 64'(err0), 64'd0);
        check("err1", 64'(err1), 64'd0);
        check("err2", 64'(err2), 64'(err_m));
`endif
    endtask

    // Drive one cycle, advance the reference queue, then compare.
    task automatic cyc(input bit rst, input bit v, input int a, input bit y);
        int n;
        reset_i = rst;
        v_i     = v;
        addr_i  = 5'(a);
        yumi_i  = y;
        n = q.size();
        @(posedge clk);
        if (rst) begin
            q.delete();
            err_m = 1'b0;
        end else begin
            if (y && n > 0)
                void'(q.pop_front());
            if (v && n < 2) begin
                q.push_back(a);
                if (a >= 24)
                    err_m = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        addr_i  = '0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_ready", 64'(ready0), 64'd1);
        check("rst_o", 64'(o0), 64'd0);

        cyc(0, 1, 5, 0);
        check("a5_o", 64'(o0), 64'h20);
        check("a5_v", 64'(v0), 64'd1);
        cyc(0, 0, 0, 1);
        check("a5_gone", 64'(v0), 64'd0);

        cyc(0, 1, 0, 0);
        check("hi_a0", 64'(o1), 64'h8000_0000);
        cyc(0, 1, 31, 1);
        check("hi_a31", 64'(o1), 64'h1);
        cyc(0, 0, 0, 1);

        cyc(0, 1, 3, 0);
        cyc(0, 1, 7, 0);
        check("full_ready", 64'(ready0), 64'd0);
        cyc(0, 1, 9, 0);
        check("q_o3", 64'(o0), 64'h8);
        cyc(0, 1, 9, 1);
        check("q_o7", 64'(o0), 64'h80);
        cyc(0, 1, 9, 1);
        check("q_o9", 64'(o0), 64'h200);
        cyc(0, 0, 0, 1);

        cyc(0, 1, 0, 0);
        for (int i = 1; i < 32; i++) begin
            cyc(0, 1, i, 1);
            check("stream_o", 64'(o0), 64'd1 << i);
            check("stream_1h", 64'($onehot(o0)), 64'd1);
        end
        cyc(0, 0, 0, 1);

        cyc(0, 1, 30, 0);
        check("oor_o", 64'(o2), 64'd0);
        check("oor_v", 64'(v2), 64'd1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 4, 0);
        cyc(0, 1, 6, 0);
        cyc(1, 1, 8, 1);
        check("midrst_v", 64'(v0), 64'd0);
        check("midrst_o", 64'(o0), 64'd0);
        check("midrst_rdy", 64'(ready0), 64'd1);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            bit r, v, y;
            int a;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = int'($urandom_range(0, 31));
            y = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            cyc(r, v, a, y);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
